// File: rtl/touch_cv_glide.sv
// touch_cv_glide: per-channel touch magnitude to signed CV converter.
// One channel per clk through a shared datapath; direct/glide/latch/gate modes.
module touch_cv_glide #(
    parameter int W    = 16,
    parameter int N_CH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic [8*N_CH-1:0]   touch,
    input  logic [N_CH-1:0]     jack,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [7:0]          threshold,
    input  logic [3:0]          glide_shift,
    output logic [W*N_CH-1:0]   sample_out,
    output logic                out_valid,
    output logic                busy
);

    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PAD = W - 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]       ch;
    logic                ch_last;
    logic                sample_clk_q;
    logic                frame_edge;

    logic [7:0]          touch_q [N_CH];
    logic [1:0]          mode_q  [N_CH];
    logic [N_CH-1:0]     jack_q;
    logic [7:0]          thr_q;
    logic [3:0]          shift_q;

    logic signed [W-1:0] y [N_CH];

    logic [7:0]          touch_k;
    logic signed [W-1:0] y_k;
    logic signed [W-1:0] t;
    logic signed [W-1:0] gate_hi;
    logic signed [W:0]   d;
    logic signed [W:0]   s;
    logic signed [W-1:0] glide_r;
    logic signed [W-1:0] r;
    logic                pressed;

    assign frame_edge = sample_clk & ~sample_clk_q;
    assign ch_last    = (ch == CW'(N_CH - 1));

    assign touch_k = touch_q[ch];
    assign y_k     = y[ch];
    assign t       = W'(touch_k) << PAD;
    assign gate_hi = W'(8'hFF) << PAD;
    assign pressed = (touch_k >= thr_q);

    always_comb begin
        d = {t[W-1], t} - {y_k[W-1], y_k};
        s = d >>> shift_q;
        // a residual step below one LSB still moves one LSB toward target
        if (s == '0 && d != '0) begin
            s = d[W] ? '1 : (W+1)'(1);
        end
        glide_r = y_k + s[W-1:0];
    end

    always_comb begin
        r = y_k;
        if (jack_q[ch]) begin
            r = '0;
        end else begin
            unique case (mode_q[ch])
                2'd0:    r = t;
                2'd1:    r = glide_r;
                2'd2:    r = pressed ? t : y_k;
                default: r = pressed ? gate_hi : '0;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_edge) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (ch_last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sample_clk_q <= 1'b0;
            ch           <= '0;
            jack_q       <= '0;
            thr_q        <= '0;
            shift_q      <= '0;
            for (int k = 0; k < N_CH; k++) begin
                touch_q[k] <= '0;
                mode_q[k]  <= '0;
                y[k]       <= '0;
            end
        end else begin
            sample_clk_q <= sample_clk;
            state        <= state_nx;
            if (state == IDLE && frame_edge) begin
                ch      <= '0;
                jack_q  <= jack;
                thr_q   <= threshold;
                shift_q <= glide_shift;
                for (int k = 0; k < N_CH; k++) begin
                    touch_q[k] <= touch[8*k +: 8];
                    mode_q[k]  <= mode[2*k +: 2];
                end
            end
            if (state == RUN) begin
                y[ch] <= r;
                ch    <= ch + 1'b1;
            end
        end
    end

    // the output register is the per-channel state itself
    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign sample_out[W*g +: W] = y[g];
    end

endmodule

// File: tb/tb_touch_cv_glide.sv
// tb_touch_cv_glide: directed vectors for touch_cv_glide (W=16, N_CH=4).
// Frames are driven by a task that also records busy/out_valid timing.
module tb_touch_cv_glide;

    localparam int W = 16;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_clk = 1'b0;
    logic [31:0] touch = '0;
    logic [3:0]  jack = '0;
    logic [7:0]  mode = '0;
    logic [7:0]  threshold = '0;
    logic [3:0]  glide_shift = '0;
    logic [63:0] sample_out;
    logic        out_valid;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] so_hist [14];

    always #5 clk = ~clk;

    touch_cv_glide #(.W(W), .N_CH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clk  (sample_clk),
        .touch       (touch),
        .jack        (jack),
        .mode        (mode),
        .threshold   (threshold),
        .glide_shift (glide_shift),
        .sample_out  (sample_out),
        .out_valid   (out_valid),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane(input logic [63:0] v, input int k);
        return v[16*k +: 16];
    endfunction

    // starts at posedge+1 with sample_clk low; returns at posedge+1
    task automatic frame(input bit glitch, input bit rearm);
        logic [15:0] bm, vm, be, ve;
        bm = '0;
        vm = '0;
        sample_clk = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bm[i] = busy;
            vm[i] = out_valid;
            so_hist[i] = sample_out;
            if (glitch && i == 1) sample_clk = 1'b0;
            if (glitch && i == 2) sample_clk = 1'b1;
            if (rearm && i == 5) sample_clk = 1'b0;
            if (rearm && i == 6) sample_clk = 1'b1;
        end
        sample_clk = 1'b0;
        @(posedge clk);
        #1;
        be = 16'h001E | (rearm ? 16'h0780 : 16'h0000);
        ve = 16'h0020 | (rearm ? 16'h0800 : 16'h0000);
        chk("busy_mask", 64'(bm), 64'(be));
        chk("valid_mask", 64'(vm), 64'(ve));
    endtask

    logic [15:0] prev, cur;
    int          guard;
    int          pulses;

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", sample_out, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);

        touch = {8'd255, 8'd128, 8'd20, 8'd10};
        @(posedge clk);
        #1 rst = 1'b1;

        frame(1'b0, 1'b0);
        chk("direct_all", sample_out, 64'h3FC0_2000_0500_0280);
        chk("lat_ch0_pre", 64'(lane(so_hist[1], 0)), 64'd0);
        chk("lat_ch0", 64'(lane(so_hist[2], 0)), 64'd640);
        chk("lat_ch1_pre", 64'(lane(so_hist[2], 1)), 64'd0);
        chk("lat_ch1", 64'(lane(so_hist[3], 1)), 64'd1280);
        chk("lat_ch3_pre", 64'(lane(so_hist[4], 3)), 64'd0);
        chk("lat_ch3", 64'(lane(so_hist[5], 3)), 64'd16320);

        rst = 1'b0;
        #1;
        chk("rst_pulse_out", sample_out, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        mode = {2'd0, 2'd0, 2'd0, 2'd1};
        glide_shift = 4'd2;
        touch = {8'd0, 8'd0, 8'd0, 8'd255};
        frame(1'b0, 1'b0);
        chk("glide_1", 64'(lane(sample_out, 0)), 64'd4080);
        frame(1'b0, 1'b0);
        chk("glide_2", 64'(lane(sample_out, 0)), 64'd7140);
        frame(1'b0, 1'b0);
        chk("glide_3", 64'(lane(sample_out, 0)), 64'd9435);
        prev = lane(sample_out, 0);
        guard = 0;
        while (lane(sample_out, 0) != 16'd16320 && guard < 60) begin
            frame(1'b0, 1'b0);
            cur = lane(sample_out, 0);
            chk("glide_up_mono", 64'(cur > prev && cur <= 16'd16320), 64'd1);
            prev = cur;
            guard++;
        end
        chk("glide_up_final", 64'(lane(sample_out, 0)), 64'd16320);
        frame(1'b0, 1'b0);
        chk("glide_hold", 64'(lane(sample_out, 0)), 64'd16320);

        touch = '0;
        frame(1'b0, 1'b0);
        chk("glide_dn_1", 64'(lane(sample_out, 0)), 64'd12240);
        prev = lane(sample_out, 0);
        guard = 0;
        while (lane(sample_out, 0) != 16'd0 && guard < 60) begin
            frame(1'b0, 1'b0);
            cur = lane(sample_out, 0);
            chk("glide_dn_mono", 64'(cur < prev), 64'd1);
            prev = cur;
            guard++;
        end
        chk("glide_dn_final", 64'(lane(sample_out, 0)), 64'd0);

        mode = {2'd0, 2'd3, 2'd2, 2'd0};
        threshold = 8'd50;
        touch = {8'd0, 8'd60, 8'd100, 8'd0};
        frame(1'b0, 1'b0);
        chk("latch_on", 64'(lane(sample_out, 1)), 64'd6400);
        chk("gate_on", 64'(lane(sample_out, 2)), 64'd16320);
        touch = {8'd0, 8'd40, 8'd30, 8'd0};
        frame(1'b0, 1'b0);
        chk("latch_hold", 64'(lane(sample_out, 1)), 64'd6400);
        chk("gate_off", 64'(lane(sample_out, 2)), 64'd0);
        threshold = 8'd30;
        touch = {8'd0, 8'd0, 8'd30, 8'd0};
        frame(1'b0, 1'b0);
        chk("latch_eq_thr", 64'(lane(sample_out, 1)), 64'd1920);
        chk("gate_zero", 64'(lane(sample_out, 2)), 64'd0);
        threshold = 8'd0;
        touch = {8'd0, 8'd0, 8'd5, 8'd0};
        frame(1'b0, 1'b0);
        chk("latch_thr0", 64'(lane(sample_out, 1)), 64'd320);
        chk("gate_thr0", 64'(lane(sample_out, 2)), 64'd16320);

        mode = '0;
        touch = {8'd255, 8'd0, 8'd0, 8'd10};
        frame(1'b0, 1'b0);
        chk("jack_prep", 64'(lane(sample_out, 3)), 64'd16320);
        mode = {2'd1, 6'd0};
        glide_shift = 4'd1;
        frame(1'b0, 1'b0);
        chk("glide_at_tgt", 64'(lane(sample_out, 3)), 64'd16320);
        jack = 4'b1000;
        frame(1'b0, 1'b0);
        chk("jack_mute", 64'(lane(sample_out, 3)), 64'd0);
        chk("jack_other", 64'(lane(sample_out, 0)), 64'd640);
        jack = 4'b0000;
        frame(1'b0, 1'b0);
        chk("jack_restart", 64'(lane(sample_out, 3)), 64'd8160);

        mode = '0;
        touch = {8'd255, 8'd128, 8'd20, 8'd10};
        frame(1'b1, 1'b1);
        chk("glitch_frame", sample_out, 64'h3FC0_2000_0500_0280);

        touch = {8'd1, 8'd2, 8'd3, 8'd4};
        sample_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sample_clk = 1'b0;
        #1;
        chk("rst_mid_out", sample_out, 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(out_valid);
        end
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            pulses += int'(out_valid);
        end
        chk("rst_mid_novalid", 64'(pulses), 64'd0);
        chk("rst_mid_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        frame(1'b0, 1'b0);
        chk("post_rst_frame", sample_out, 64'h0040_0080_00C0_0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
